// File: rtl/imul_iter_if.sv
// rtl/imul_iter_if.sv - request/response val/rdy bundle for the iterative multiplier
interface imul_iter_if #(
  parameter int NBITS = 32
);
  logic [2*NBITS-1:0] req_msg;
  logic               req_val;
  logic               req_rdy;
  logic [NBITS-1:0]   resp_msg;
  logic               resp_val;
  logic               resp_rdy;

  modport master (
    output req_msg, req_val, resp_rdy,
    input  req_rdy, resp_msg, resp_val
  );

  modport slave (
    input  req_msg, req_val, resp_rdy,
    output req_rdy, resp_msg, resp_val
  );
endinterface

// File: rtl/imul_iter.sv
// rtl/imul_iter.sv - fixed 32-step shift-add multiplier returning the low product word
module imul_iter #(
  parameter int NBITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  imul_iter_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] result_q, result_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             req_rdy_c;
  logic             resp_val_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    req_rdy_c  = 1'b0;
    resp_val_c = 1'b0;
    case (state_q)
      CALC: begin
        // Always 32 steps, even once b is exhausted, so latency is operand-independent.
        if (b_q[0]) begin
          result_d = result_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        resp_val_c = 1'b1;
        if (io.resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        // IDLE and the unused encoding behave identically.
        req_rdy_c = 1'b1;
        state_d   = IDLE;
        if (io.req_val) begin
          a_d      = io.req_msg[2*NBITS-1:NBITS];
          b_d      = io.req_msg[NBITS-1:0];
          result_d = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
    endcase
  end

  assign io.req_rdy  = req_rdy_c & ~reset;
  assign io.resp_val = resp_val_c;
  assign io.resp_msg = result_q;

endmodule
